multi_cycle_ctrl: RTL

Control state machine for the multi-cycle version of the MIPS-subset CPU. It sequences a shared datapath with one ALU, a unified memory port, an IR and A/B/ALUOut holding registers. The datapath executes each instruction over 3-5 states instead of one cycle. The block drives every datapath mux and write-enable, and waits on a memory-ready handshake with a bus timeout. It also counts retired instructions and halts on illegal opcodes or bus errors.

---
 rtl/multi_cycle_ctrl_if.sv | 48 ++++
 rtl/multi_cycle_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The controller side is the master; the datapath/memory side is the slave.
interface multi_cycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode_i;
  logic [5:0]       funct_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             pc_write_cond_o;
  logic             branch_ne_o;
  logic [1:0]       pc_source_o;
  logic             i_or_d_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             ir_write_o;
  logic [1:0]       reg_dst_o;
  logic [1:0]       mem_to_reg_o;
  logic             reg_write_o;
  logic             alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [1:0]       alu_op_o;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] retired_o;
  logic             illegal_o;
  logic             bus_err_o;
  logic             halted_o;

  modport master (
    input  opcode_i, funct_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, branch_ne_o,
    output pc_source_o, i_or_d_o, mem_read_o,
    output mem_write_o, ir_write_o, reg_dst_o,
    output mem_to_reg_o, reg_write_o, alu_src_a_o,
    output alu_src_b_o, alu_op_o, state_o,
    output retired_o, illegal_o, bus_err_o, halted_o
  );

  modport slave (
    output opcode_i, funct_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, branch_ne_o,
    input  pc_source_o, i_or_d_o, mem_read_o,
    input  mem_write_o, ir_write_o, reg_dst_o,
    input  mem_to_reg_o, reg_write_o, alu_src_a_o,
    input  alu_src_b_o, alu_op_o, state_o,
    input  retired_o, illegal_o, bus_err_o, halted_o
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences the shared datapath,
// waits on memory with a bus timeout, counts retirements, halts on faults.
module multi_cycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  multi_cycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    JR       = 4'd12,
    JAL      = 4'd13,
    HALT     = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic [5:0] op;
  logic       rdy;
  logic       expired;
  logic       retire;

  assign op      = bus.opcode_i;
  assign rdy     = bus.mem_ready_i;
  assign expired = (wait_q == WAIT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    bus.pc_write_o      = 1'b0;
    bus.pc_write_cond_o = 1'b0;
    bus.branch_ne_o     = 1'b0;
    bus.pc_source_o     = 2'b00;
    bus.i_or_d_o        = 1'b0;
    bus.mem_read_o      = 1'b0;
    bus.mem_write_o     = 1'b0;
    bus.ir_write_o      = 1'b0;
    bus.reg_dst_o       = 2'b00;
    bus.mem_to_reg_o    = 2'b00;
    bus.reg_write_o     = 1'b0;
    bus.alu_src_a_o     = 1'b0;
    bus.alu_src_b_o     = 2'b00;
    bus.alu_op_o        = 2'b00;
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;

    unique case (state_q)
      FETCH: begin
        bus.mem_read_o  = 1'b1;
        bus.alu_src_b_o = 2'b01;
        bus.ir_write_o  = rdy;
        bus.pc_write_o  = rdy;
        if (rdy) begin
          state_d = DECODE;
        end else if (expired) begin
          state_d   = HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DECODE: begin
        bus.alu_src_b_o = 2'b11;
        unique case (1'b1)
          op == OP_R && bus.funct_i == FN_JR: state_d = JR;
          op == OP_R && bus.funct_i != FN_JR: state_d = R_EXEC;
          op == OP_LW || op == OP_SW:         state_d = MEM_ADDR;
          op == OP_BEQ || op == OP_BNE:       state_d = BRANCH;
          op == OP_J:                         state_d = JUMP;
          op == OP_JAL:                       state_d = JAL;
          op == OP_ADDI || op == OP_SLTI ||
          op == OP_ORI || op == OP_LUI:       state_d = I_EXEC;
          default: begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'b10;
        state_d = (op == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        bus.mem_read_o = 1'b1;
        bus.i_or_d_o   = 1'b1;
        if (rdy) begin
          state_d = MEM_WB;
        end else if (expired) begin
          state_d   = HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      MEM_WB: begin
        bus.reg_write_o  = 1'b1;
        bus.mem_to_reg_o = 2'b01;
        retire = 1'b1;
      end
      MEM_WR: begin
        bus.mem_write_o = 1'b1;
        bus.i_or_d_o    = 1'b1;
        if (rdy) begin
          retire = 1'b1;
        end else if (expired) begin
          state_d   = HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      R_EXEC: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_op_o    = 2'b10;
        state_d = R_WB;
      end
      R_WB: begin
        bus.reg_write_o = 1'b1;
        bus.reg_dst_o   = 2'b01;
        retire = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a_o     = 1'b1;
        bus.alu_op_o        = 2'b01;
        bus.pc_write_cond_o = 1'b1;
        bus.pc_source_o     = 2'b01;
        bus.branch_ne_o     = (op == OP_BNE);
        retire = 1'b1;
      end
      JUMP: begin
        bus.pc_write_o  = 1'b1;
        bus.pc_source_o = 2'b10;
        retire = 1'b1;
      end
      I_EXEC: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'b10;
        bus.alu_op_o    = 2'b11;
        state_d = I_WB;
      end
      I_WB: begin
        bus.reg_write_o  = 1'b1;
        bus.mem_to_reg_o = (op == OP_LUI) ? 2'b10 : 2'b00;
        retire = 1'b1;
      end
      JR: begin
        bus.pc_write_o  = 1'b1;
        bus.pc_source_o = 2'b11;
        retire = 1'b1;
      end
      JAL: begin
        bus.pc_write_o   = 1'b1;
        bus.pc_source_o  = 2'b10;
        bus.reg_write_o  = 1'b1;
        bus.reg_dst_o    = 2'b10;
        bus.mem_to_reg_o = 2'b11;
        retire = 1'b1;
      end
      HALT: state_d = HALT;
      default: state_d = HALT;
    endcase

    if (retire) state_d = FETCH;
    if (state_d != state_q) wait_d = '0;
  end

  assign retired_d     = retire ? retired_q + CNT_W'(1) : retired_q;
  assign bus.state_o   = state_q;
  assign bus.retired_o = retired_q;
  assign bus.illegal_o = illegal_q;
  assign bus.bus_err_o = bus_err_q;
  assign bus.halted_o  = (state_q == HALT);

endmodule
